lcd_window_writer: RTL and testbench

- Parametrised successor to the fixed full-screen RAM fill stage of the ST7789V3 driver.
- On a start request, writes an arbitrary rectangular window: emits CASET/RASET/RAMWR commands with offset-corrected coordinates, then streams upstream pixels as bytes.
- Supports RGB565 and RGB666 modes.
- Sits between a pixel source and the 9-bit command/data word FIFO that feeds the SPI serdes.

---
 rtl/lcd_window_writer.sv | 251 +++++++++++++++++++++++++
 tb/tb_lcd_window_writer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_window_writer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : lcd_window_writer
// Brief   : Writes a rectangular ST7789V3 window (CASET/RASET/RAMWR + pixels)
//           into the 9-bit command/data word stream.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module lcd_window_writer #(
   parameter int PIXEL_WIDTH = 16,
   parameter int COORD_WIDTH = 9,
   parameter int X_OFFSET    = 0,
   parameter int Y_OFFSET    = 20,
   parameter int MAX_X       = 239,
   parameter int MAX_Y       = 279
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start_i,
   input  logic [COORD_WIDTH-1:0] x0_i,
   input  logic [COORD_WIDTH-1:0] x1_i,
   input  logic [COORD_WIDTH-1:0] y0_i,
   input  logic [COORD_WIDTH-1:0] y1_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   err_o,
   input  logic                   px_valid_i,
   output logic                   px_ready_o,
   input  logic [PIXEL_WIDTH-1:0] px_data_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [8:0]             out_data_o
);

   localparam int c_bpp   = (PIXEL_WIDTH == 18) ? 3 : 2;
   localparam int c_cnt_w = $clog2((MAX_X + 1) * (MAX_Y + 1) + 1);

   localparam logic [2:0] c_st_idle   = 3'd0;
   localparam logic [2:0] c_st_caset  = 3'd1;
   localparam logic [2:0] c_st_raset  = 3'd2;
   localparam logic [2:0] c_st_ramwr  = 3'd3;
   localparam logic [2:0] c_st_pixels = 3'd4;

   localparam logic [COORD_WIDTH-1:0] c_max_x = COORD_WIDTH'(MAX_X);
   localparam logic [COORD_WIDTH-1:0] c_max_y = COORD_WIDTH'(MAX_Y);
   // Byte index value meaning every byte of the held pixel is in the output register
   localparam logic [1:0]             c_all_loaded = 2'(c_bpp);

   logic [2:0]             state_q, state_d;
   logic [2:0]             idx_q, idx_d;
   logic [c_cnt_w-1:0]     left_q, left_d;
   logic [PIXEL_WIDTH-1:0] hold_q, hold_d;
   logic                   hold_full_q, hold_full_d;
   logic [1:0]             bidx_q, bidx_d;
   logic                   out_valid_q, out_valid_d;
   logic [8:0]             out_data_q, out_data_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;
   logic [COORD_WIDTH-1:0] x0_q, x1_q, y0_q, y1_q;

   logic                   w_out_free;
   logic                   w_illegal;
   logic                   w_accept;
   logic [c_cnt_w-1:0]     w_cols, w_rows, w_npix;
   logic [15:0]            w_cx0, w_cx1, w_cy0, w_cy1;
   logic [15:0]            w_lo_bound, w_hi_bound;
   logic [7:0]             w_opcode;
   logic [8:0]             w_cmd_word;
   logic                   w_last_xfer;
   logic                   w_px_ready;
   logic                   w_capture;
   logic [7:0]             w_hold_byte;
   logic [7:0]             w_px_byte0;

   assign w_out_free = !out_valid_q || out_ready_i;
   assign w_illegal  = (x0_i > x1_i) || (y0_i > y1_i) || (x1_i > c_max_x) || (y1_i > c_max_y);
   assign w_accept   = (state_q == c_st_idle) && start_i && !w_illegal;

   assign w_cols = c_cnt_w'(x1_i) - c_cnt_w'(x0_i) + c_cnt_w'(1);
   assign w_rows = c_cnt_w'(y1_i) - c_cnt_w'(y0_i) + c_cnt_w'(1);
   assign w_npix = w_cols * w_rows;

   assign w_cx0 = 16'(x0_q) + 16'(X_OFFSET);
   assign w_cx1 = 16'(x1_q) + 16'(X_OFFSET);
   assign w_cy0 = 16'(y0_q) + 16'(Y_OFFSET);
   assign w_cy1 = 16'(y1_q) + 16'(Y_OFFSET);

   assign w_lo_bound = (state_q == c_st_caset) ? w_cx0 : w_cy0;
   assign w_hi_bound = (state_q == c_st_caset) ? w_cx1 : w_cy1;
   assign w_opcode   = (state_q == c_st_caset) ? 8'h2A : 8'h2B;

   always_comb begin
      w_cmd_word = {1'b0, w_opcode};
      case (idx_q)
         3'd0:    w_cmd_word = {1'b0, w_opcode};
         3'd1:    w_cmd_word = {1'b1, w_lo_bound[15:8]};
         3'd2:    w_cmd_word = {1'b1, w_lo_bound[7:0]};
         3'd3:    w_cmd_word = {1'b1, w_hi_bound[15:8]};
         default: w_cmd_word = {1'b1, w_hi_bound[7:0]};
      endcase
   end

   // The held pixel's last byte is in the output register and leaves this cycle
   assign w_last_xfer = hold_full_q && (bidx_q == c_all_loaded) && out_valid_q && out_ready_i;
   assign w_px_ready  = (state_q == c_st_pixels) && (left_q != '0) && (!hold_full_q || w_last_xfer);
   assign w_capture   = w_px_ready && px_valid_i;

   generate
      if (PIXEL_WIDTH == 18) begin : g_rgb666
         always_comb begin
            case (bidx_q)
               2'd0:    w_hold_byte = {hold_q[17:12], 2'b00};
               2'd1:    w_hold_byte = {hold_q[11:6], 2'b00};
               default: w_hold_byte = {hold_q[5:0], 2'b00};
            endcase
         end
         assign w_px_byte0 = {px_data_i[17:12], 2'b00};
      end else begin : g_rgb565
         assign w_hold_byte = (bidx_q == 2'd0) ? hold_q[15:8] : hold_q[7:0];
         assign w_px_byte0  = px_data_i[15:8];
      end
   endgenerate

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      left_d      = left_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      bidx_d      = bidx_q;
      out_valid_d = out_valid_q && !out_ready_i;
      out_data_d  = out_data_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      err_d       = 1'b0;

      case (state_q)
         c_st_idle: begin
            if (start_i) begin
               if (w_illegal) begin
                  err_d = 1'b1;
               end else begin
                  state_d = c_st_caset;
                  idx_d   = 3'd0;
                  left_d  = w_npix;
                  busy_d  = 1'b1;
               end
            end
         end
         c_st_caset, c_st_raset: begin
            if (w_out_free) begin
               out_valid_d = 1'b1;
               out_data_d  = w_cmd_word;
               if (idx_q == 3'd4) begin
                  idx_d   = 3'd0;
                  state_d = (state_q == c_st_caset) ? c_st_raset : c_st_ramwr;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         c_st_ramwr: begin
            if (w_out_free) begin
               out_valid_d = 1'b1;
               out_data_d  = 9'h02C;
               state_d     = c_st_pixels;
            end
         end
         c_st_pixels: begin
            if (hold_full_q && (bidx_q != c_all_loaded)) begin
               if (w_out_free) begin
                  out_valid_d = 1'b1;
                  out_data_d  = {1'b1, w_hold_byte};
                  bidx_d      = bidx_q + 2'd1;
               end
            end else if (w_capture) begin
               // First byte bypasses the holding register so pixels stream without a bubble
               hold_d      = px_data_i;
               hold_full_d = 1'b1;
               left_d      = left_q - c_cnt_w'(1);
               if (w_out_free) begin
                  out_valid_d = 1'b1;
                  out_data_d  = {1'b1, w_px_byte0};
                  bidx_d      = 2'd1;
               end else begin
                  bidx_d = 2'd0;
               end
            end else if (w_last_xfer) begin
               hold_full_d = 1'b0;
            end

            if (w_last_xfer && (left_q == '0)) begin
               state_d = c_st_idle;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = c_st_idle;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= c_st_idle;
         idx_q       <= 3'd0;
         left_q      <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         bidx_q      <= 2'd0;
         out_valid_q <= 1'b0;
         out_data_q  <= 9'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         x0_q        <= '0;
         x1_q        <= '0;
         y0_q        <= '0;
         y1_q        <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         left_q      <= left_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         bidx_q      <= bidx_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         if (w_accept) begin
            x0_q <= x0_i;
            x1_q <= x1_i;
            y0_q <= y0_i;
            y1_q <= y1_i;
         end
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign px_ready_o  = w_px_ready;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_window_writer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_lcd_window_writer
// Brief   : Self-checking bench for lcd_window_writer (RGB565 and RGB666 DUTs).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_lcd_window_writer;

   localparam int c_xo = 0;
   localparam int c_yo = 20;

   logic        clk = 1'b0;
   logic        rst;
   logic        start16, start18;
   logic [8:0]  x0, x1, y0, y1;
   logic        px_valid;
   logic [17:0] px_data;
   logic        out_ready;

   logic       busy16, done16, err16, pxr16, ov16;
   logic [8:0] od16;
   logic       busy18, done18, err18, pxr18, ov18;
   logic [8:0] od18;

   always #5 clk = ~clk;

   lcd_window_writer #(.PIXEL_WIDTH(16)) u_dut16 (
      .clk(clk), .rst(rst), .start_i(start16),
      .x0_i(x0), .x1_i(x1), .y0_i(y0), .y1_i(y1),
      .busy_o(busy16), .done_o(done16), .err_o(err16),
      .px_valid_i(px_valid), .px_ready_o(pxr16), .px_data_i(px_data[15:0]),
      .out_valid_o(ov16), .out_ready_i(out_ready), .out_data_o(od16)
   );

   lcd_window_writer #(.PIXEL_WIDTH(18)) u_dut18 (
      .clk(clk), .rst(rst), .start_i(start18),
      .x0_i(x0), .x1_i(x1), .y0_i(y0), .y1_i(y1),
      .busy_o(busy18), .done_o(done18), .err_o(err18),
      .px_valid_i(px_valid), .px_ready_o(pxr18), .px_data_i(px_data),
      .out_valid_o(ov18), .out_ready_i(out_ready), .out_data_o(od18)
   );

   bit         sel;
   logic       s_ov, s_busy, s_done, s_err, s_pxr;
   logic [8:0] s_od;
   assign s_ov   = sel ? ov18   : ov16;
   assign s_od   = sel ? od18   : od16;
   assign s_busy = sel ? busy18 : busy16;
   assign s_done = sel ? done18 : done16;
   assign s_err  = sel ? err18  : err16;
   assign s_pxr  = sel ? pxr18  : pxr16;

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [8:0]  got_q[$];
   logic [8:0]  exp_q[$];
   logic [17:0] src_px[$];
   logic [17:0] pix_fifo[$];
   int          cyc, last_xfer_cyc, done_cyc, done_cnt, err_cnt, cap_cnt;
   bit          prev_stall;
   logic [8:0]  prev_data;
   int          rmode, vmode, gap_at, gap_left;
   bit          gap_done, stray;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference word stream: window commands, then every pixel split into bytes
   function automatic void push_pair(input int v);
      exp_q.push_back(9'(256 + ((v >> 8) & 255)));
      exp_q.push_back(9'(256 + (v & 255)));
   endfunction

   function automatic void build_expected(input bit is18, input int x0v, x1v, y0v, y1v);
      exp_q.delete();
      exp_q.push_back(9'h02A);
      push_pair(x0v + c_xo);
      push_pair(x1v + c_xo);
      exp_q.push_back(9'h02B);
      push_pair(y0v + c_yo);
      push_pair(y1v + c_yo);
      exp_q.push_back(9'h02C);
      foreach (src_px[i]) begin
         int p;
         p = int'(src_px[i]);
         if (is18) begin
            for (int b = 0; b < 3; b++)
               exp_q.push_back(9'(256 + (((p >> (12 - 6 * b)) & 63) << 2)));
         end else begin
            push_pair(p & 16'hFFFF);
         end
      end
   endfunction

   task automatic drive_inputs();
      case (rmode)
         0:       out_ready = 1'b1;
         1:       out_ready = ~out_ready;
         default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (gap_left > 0) gap_left--;
      if (gap_at > 0 && cap_cnt == gap_at && !gap_done) begin
         gap_left = 10;
         gap_done = 1'b1;
      end
      px_valid = (pix_fifo.size() > 0) && (gap_left == 0) && (vmode == 0 || $urandom_range(0, 2) != 0);
      px_data  = px_valid ? pix_fifo[0] : 18'($urandom);
      start16 = 1'b0;
      start18 = 1'b0;
      if (stray && s_busy && $urandom_range(0, 15) == 0) begin
         x0 = 9'd5; x1 = 9'd4;
         if (sel) start18 = 1'b1; else start16 = 1'b1;
      end
   endtask

   task automatic cycle();
      bit cap;
      @(negedge clk);
      cyc++;
      if (prev_stall) begin
         check("stall_valid", 32'(s_ov), 32'd1);
         check("stall_data", 32'(s_od), 32'(prev_data));
      end
      if (s_ov && out_ready) begin
         got_q.push_back(s_od);
         last_xfer_cyc = cyc;
      end
      if (s_done) begin
         done_cnt++;
         done_cyc = cyc;
         check("done_busy", 32'(s_busy), 32'd0);
      end
      if (s_err) err_cnt++;
      if (gap_left > 0 && gap_left <= 6) check("gap_idle", 32'(s_ov), 32'd0);
      prev_stall = s_ov && !out_ready;
      prev_data  = s_od;
      cap = px_valid && s_pxr;
      @(posedge clk);
      #1;
      if (cap) begin
         void'(pix_fifo.pop_front());
         cap_cnt++;
      end
      drive_inputs();
   endtask

   task automatic run_window(input bit is18, input int x0v, x1v, y0v, y1v,
                             input int rm, input int vm, input int gap);
      int n;
      int budget;
      sel = is18; rmode = rm; vmode = vm; gap_at = gap; gap_left = 0; gap_done = 1'b0;
      n = (x1v - x0v + 1) * (y1v - y0v + 1);
      while (src_px.size() < n)
         src_px.push_back(is18 ? 18'($urandom) : 18'($urandom_range(0, 65535)));
      build_expected(is18, x0v, x1v, y0v, y1v);
      pix_fifo = src_px;
      got_q.delete();
      done_cnt = 0; err_cnt = 0; cap_cnt = 0; cyc = 0;
      last_xfer_cyc = -1; done_cyc = -1; prev_stall = 1'b0;
      x0 = 9'(x0v); x1 = 9'(x1v); y0 = 9'(y0v); y1 = 9'(y1v);
      px_valid = 1'b0;
      if (is18) start18 = 1'b1; else start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0; start18 = 1'b0;
      check("accept_err", 32'(s_err), 32'd0);
      @(posedge clk); #1;
      check("lat_valid", 32'(s_ov), 32'd1);
      check("lat_data", 32'(s_od), 32'h02A);
      check("lat_busy", 32'(s_busy), 32'd1);
      drive_inputs();
      budget = 0;
      while (done_cnt == 0 && budget < 4000) begin
         cycle();
         budget++;
      end
      check("done_seen", 32'(done_cnt), 32'd1);
      cycle();
      cycle();
      check("done_once", 32'(done_cnt), 32'd1);
      check("done_after_last", 32'(done_cyc), 32'(last_xfer_cyc + 1));
      check("no_err_busy", 32'(err_cnt), 32'd0);
      check("pix_taken", 32'(cap_cnt), 32'(n));
      check("word_count", 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         check($sformatf("word%0d", i), (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD, 32'(exp_q[i]));
      src_px.delete();
      stray = 1'b0;
   endtask

   task automatic try_illegal(input int x0v, x1v, y0v, y1v, input string tag);
      sel = 1'b0;
      x0 = 9'(x0v); x1 = 9'(x1v); y0 = 9'(y0v); y1 = 9'(y1v);
      start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0;
      check({tag, "_err"}, 32'(err16), 32'd1);
      check({tag, "_busy"}, 32'(busy16), 32'd0);
      check({tag, "_valid"}, 32'(ov16), 32'd0);
      @(posedge clk); #1;
      check({tag, "_err_1cyc"}, 32'(err16), 32'd0);
      check({tag, "_busy2"}, 32'(busy16), 32'd0);
      check({tag, "_valid2"}, 32'(ov16), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int b;
      rst = 1'b0; start16 = 1'b0; start18 = 1'b0;
      x0 = '0; x1 = '0; y0 = '0; y1 = '0;
      px_valid = 1'b0; px_data = '0; out_ready = 1'b0;
      sel = 1'b0; stray = 1'b0; rmode = 0; vmode = 0; gap_at = 0; gap_left = 0; gap_done = 1'b0;
      #1;
      check("rst_valid", 32'(ov16), 32'd0);
      check("rst_data", 32'(od16), 32'd0);
      check("rst_busy", 32'(busy16), 32'd0);
      check("rst_done", 32'(done16), 32'd0);
      check("rst_err", 32'(err16), 32'd0);
      check("rst_pxready", 32'(pxr16), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;

      // Directed RGB565 two-pixel window
      src_px.push_back(18'h0F800);
      src_px.push_back(18'h007E0);
      run_window(1'b0, 0, 1, 0, 0, 0, 0, 0);

      // Illegal windows
      try_illegal(5, 4, 0, 0, "x_order");
      try_illegal(0, 240, 0, 0, "x_max");
      try_illegal(0, 0, 0, 280, "y_max");
      try_illegal(0, 0, 7, 6, "y_order");

      // Backpressure: ready toggles every cycle through a 1x1 window
      run_window(1'b0, 3, 3, 9, 9, 1, 0, 0);

      // RGB666 at the far corner
      src_px.push_back(18'h3FFFF);
      run_window(1'b1, 239, 239, 279, 279, 0, 0, 0);

      // Pixel starvation mid-window
      run_window(1'b0, 10, 11, 4, 5, 0, 0, 2);
      run_window(1'b1, 0, 1, 0, 0, 0, 0, 1);

      // Reset in the middle of a 4x4 window
      sel = 1'b0; rmode = 0; vmode = 0; gap_at = 0; gap_left = 0;
      for (int i = 0; i < 16; i++) src_px.push_back(18'($urandom_range(0, 65535)));
      pix_fifo = src_px;
      cap_cnt = 0; done_cnt = 0; prev_stall = 1'b0;
      x0 = 9'd0; x1 = 9'd3; y0 = 9'd0; y1 = 9'd3;
      start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0;
      drive_inputs();
      b = 0;
      while (cap_cnt < 3 && b < 200) begin
         cycle();
         b++;
      end
      check("rst_reach3", 32'(cap_cnt), 32'd3);
      #2 rst = 1'b0;
      #1;
      check("arst_valid", 32'(ov16), 32'd0);
      check("arst_data", 32'(od16), 32'd0);
      check("arst_busy", 32'(busy16), 32'd0);
      check("arst_pxready", 32'(pxr16), 32'd0);
      check("arst_done", 32'(done16), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      px_valid = 1'b0;
      pix_fifo.delete();
      src_px.delete();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("abort_no_done", 32'(done16), 32'd0);
      end
      @(posedge clk); #1;
      check("abort_done_cnt", 32'(done_cnt), 32'd0);
      run_window(1'b0, 0, 3, 0, 3, 0, 0, 0);

      // Randomized windows, randomized handshakes, stray starts while busy
      for (int t = 0; t < 8; t++) begin
         int rx, ry;
         rx = $urandom_range(0, 236);
         ry = $urandom_range(0, 276);
         stray = 1'b1;
         run_window(1'($urandom_range(0, 1)), rx, rx + $urandom_range(0, 2),
                    ry, ry + $urandom_range(0, 2), 2, 1, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
